// File: rtl/blink_decoder.sv
// Purpose: recover toggle timing from an asynchronous blink line; report lock, error and timeout.
// Latency: a led change sampled at clock edge k gives edge_flg/period/err/locked updates after edge k+2.
// Backpressure: none; this is a free-running monitor, and all outputs are registered status.
module blink_decoder #(
    parameter int CBITS  = 25,
    parameter int TOL    = 2,
    parameter int LOCK_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             led,
    output logic             edge_flg,
    output logic             level,
    output logic [CBITS:0]   period,
    output logic             locked,
    output logic             err
);

    localparam int GW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

    localparam logic [CBITS:0]   MAX   = '1;
    localparam logic [CBITS:0]   MAX_M1 = MAX - 1'b1;
    localparam logic [CBITS+1:0] NOM   = (CBITS+2)'(1) << CBITS;
    localparam logic [CBITS+1:0] W_TOL = (CBITS+2)'(TOL);
    localparam logic [CBITS+1:0] LO    = NOM - W_TOL;
    localparam logic [CBITS+1:0] HI    = NOM + W_TOL;
    localparam logic [GW-1:0]    LOCK_CNT = GW'(LOCK_N);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACQ  = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    logic           r_s1;
    logic           r_s2;
    logic           r_s3;
    logic [CBITS:0] r_ivl;
    logic [GW-1:0]  r_good_cnt;
    logic [1:0]     r_state;
    logic           r_edge_flg;
    logic [CBITS:0] r_period;
    logic           r_locked;
    logic           r_err;

    logic             w_edge;
    logic [CBITS:0]   w_m;
    logic [CBITS+1:0] w_m_ext;
    logic             w_good;
    logic             w_tmo;
    logic [GW-1:0]    w_good_next;

    // The s2/s3 pair marks a toggle; s1 only absorbs metastability.
    assign w_edge = r_s2 ^ r_s3;

    // The counter holds (interval - 1) just before an edge. Saturation caps the reported interval at MAX.
    assign w_m     = (r_ivl < MAX) ? (r_ivl + 1'b1) : MAX;
    assign w_m_ext = {1'b0, w_m};
    assign w_good  = (w_m_ext >= LO) && (w_m_ext <= HI);

    // A timeout fires only on the step into saturation, so a dead line produces a single err pulse.
    assign w_tmo       = !w_edge && (r_ivl == MAX_M1) && (r_state != ST_IDLE);
    assign w_good_next = r_good_cnt + 1'b1;

    assign edge_flg = r_edge_flg;
    assign level    = r_s2;
    assign period   = r_period;
    assign locked   = r_locked;
    assign err      = r_err;

    // Three-flop synchronizer on the asynchronous blink line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= led;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Interval counter: restarts on every toggle, otherwise counts up and saturates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ivl <= '0;
        end else if (w_edge) begin
            r_ivl <= '0;
        end else if (r_ivl != MAX) begin
            r_ivl <= r_ivl + 1'b1;
        end
    end

    // Lock tracking: classify each interval, then update state, period, locked and err
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_good_cnt <= '0;
            r_edge_flg <= 1'b0;
            r_period   <= '0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_edge_flg <= w_edge;
            r_err      <= 1'b0;
            if (w_edge) begin
                case (r_state)
                    ST_IDLE: begin
                        // The first toggle only sets the reference point, so there is nothing to measure yet.
                        r_state    <= ST_ACQ;
                        r_good_cnt <= '0;
                    end
                    ST_ACQ: begin
                        r_period <= w_m;
                        if (w_good) begin
                            if (w_good_next == LOCK_CNT) begin
                                r_state    <= ST_LOCK;
                                r_locked   <= 1'b1;
                                r_good_cnt <= '0;
                            end else begin
                                r_good_cnt <= w_good_next;
                            end
                        end else begin
                            r_err      <= 1'b1;
                            r_good_cnt <= '0;
                        end
                    end
                    ST_LOCK: begin
                        r_period <= w_m;
                        if (!w_good) begin
                            r_err      <= 1'b1;
                            r_locked   <= 1'b0;
                            r_state    <= ST_ACQ;
                            r_good_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_good_cnt <= '0;
                        r_locked   <= 1'b0;
                    end
                endcase
            end else if (w_tmo) begin
                r_err      <= 1'b1;
                r_locked   <= 1'b0;
                r_state    <= ST_IDLE;
                r_good_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_blink_decoder.sv
// Purpose: check blink_decoder (CBITS=4, TOL=1, LOCK_N=3) against a timestamp-based reference model.
// Latency: the model predicts the registered outputs for every clock, and outputs are compared on each falling edge.
// Backpressure: not applicable; the bench alone drives the led line and the reset.
module tb_blink_decoder;

    localparam int CBITS  = 4;
    localparam int TOL    = 1;
    localparam int LOCK_N = 3;
    localparam int NOM    = 16;
    localparam int MAXV   = 31;

    logic       clk;
    logic       rst;
    logic       led;
    logic       edge_flg;
    logic       level;
    logic [4:0] period;
    logic       locked;
    logic       err;

    int n_chk;
    int n_fail;
    int since;

    blink_decoder #(
        .CBITS  (CBITS),
        .TOL    (TOL),
        .LOCK_N (LOCK_N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .led      (led),
        .edge_flg (edge_flg),
        .level    (level),
        .period   (period),
        .locked   (locked),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", nm, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model records led samples and keeps edge timestamps. The measured interval is the number of
    // cycles between toggles, capped at MAX. Lock is decided by a run length of good intervals.
    bit   smp[$];
    int   cyc;
    int   last_e;
    int   mode;       // 0 = no reference, 1 = acquiring, 2 = locked
    int   goodn;
    bit   exp_edge;
    bit   exp_err;
    bit   exp_locked;
    bit   exp_level;
    int   exp_period;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp = '{1'b0, 1'b0, 1'b0};
            cyc = 0; last_e = 0; mode = 0; goodn = 0;
            exp_edge = 0; exp_err = 0; exp_locked = 0; exp_level = 0; exp_period = 0;
        end else begin
            int  d;
            int  m;
            bit  ev;
            cyc++;
            // A led change appears as an edge two clocks after it was sampled.
            ev = (smp[$-1] != smp[$-2]);
            d  = cyc - last_e;
            m  = (d > MAXV) ? MAXV : d;
            exp_edge = ev;
            exp_err  = 0;
            if (ev) begin
                if (mode == 0) begin
                    mode = 1; goodn = 0;
                end else begin
                    exp_period = m;
                    if (m >= NOM - TOL && m <= NOM + TOL) begin
                        if (mode == 1) begin
                            goodn++;
                            if (goodn >= LOCK_N) begin
                                mode = 2; goodn = 0;
                            end
                        end
                    end else begin
                        exp_err = 1; mode = 1; goodn = 0;
                    end
                end
                last_e = cyc;
            end else if (mode != 0 && d == MAXV) begin
                exp_err = 1; mode = 0; goodn = 0;
            end
            exp_locked = (mode == 2);
            exp_level  = smp[$];
            smp.push_back(led);
            if (smp.size() > 8) void'(smp.pop_front());
        end
    end

    // Compare all outputs against the model on every falling edge
    always @(negedge clk) begin
        chk("edge_flg", int'(edge_flg), int'(exp_edge));
        chk("err",      int'(err),      int'(exp_err));
        chk("locked",   int'(locked),   int'(exp_locked));
        chk("level",    int'(level),    int'(exp_level));
        chk("period",   int'(period),   exp_period);
    end

    // Toggle led a given number of falling edges after the previous toggle, with a small random skew
    task automatic tog(input int gap);
        if (gap > since) repeat (gap - since) @(negedge clk);
        #($urandom_range(0, 3));
        led   = ~led;
        since = 0;
    endtask

    // Advance to the third falling edge after a toggle, where its edge_flg is visible
    task automatic wait3();
        repeat (3) @(negedge clk);
        since += 3;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; since = 0;
        rst = 1'b0; led = 1'b0;

        // Reset held while led toggles
        repeat (6) begin
            @(negedge clk);
            #2 led = ~led;
        end
        @(negedge clk);
        chk("rst_locked", int'(locked), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_level",  int'(level), 0);
        chk("rst_edge",   int'(edge_flg), 0);
        chk("rst_err",    int'(err), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_edge", int'(edge_flg), 0);
        since = 5;

        // Steady blink with a 16-clock half-period
        tog(5);  wait3(); chk("steady_e1_flg", int'(edge_flg), 1); chk("steady_e1_period", int'(period), 0);
        tog(16); wait3(); chk("steady_e2_period", int'(period), 16);
        tog(16); wait3(); chk("steady_e3_locked", int'(locked), 0);
        tog(16); wait3(); chk("steady_e4_locked", int'(locked), 1); chk("steady_e4_err", int'(err), 0);

        // Tolerance band
        tog(15); wait3(); chk("tol15_period", int'(period), 15); chk("tol15_locked", int'(locked), 1);
        tog(17); wait3(); chk("tol17_period", int'(period), 17); chk("tol17_locked", int'(locked), 1);
        tog(18); wait3(); chk("tol18_err", int'(err), 1); chk("tol18_locked", int'(locked), 0);
        tog(16); tog(16); tog(16); wait3();
        chk("relock", int'(locked), 1);

        // Timeout: err appears on the 34th falling edge after the last toggle
        repeat (30) @(negedge clk);
        since += 30;
        chk("tmo_early_err", int'(err), 0);
        @(negedge clk); since++;
        chk("tmo_err", int'(err), 1);
        chk("tmo_locked", int'(locked), 0);
        @(negedge clk); since++;
        chk("tmo_err_once", int'(err), 0);
        tog(45); wait3();
        chk("tmo_next_flg", int'(edge_flg), 1);
        chk("tmo_next_period", int'(period), 16);
        chk("tmo_next_err", int'(err), 0);

        // Lock again, then inject a one-cycle glitch
        tog(16); tog(16); tog(16); wait3();
        chk("glitch_pre_locked", int'(locked), 1);
        tog(16); tog(1); wait3();
        chk("glitch_period", int'(period), 1);
        chk("glitch_err", int'(err), 1);
        chk("glitch_locked", int'(locked), 0);

        // Randomized intervals: mostly nominal, with some in-band, short and long intervals
        for (int i = 0; i < 60; i++) begin
            int r;
            int g;
            r = $urandom_range(0, 9);
            if (r <= 5)      g = 16;
            else if (r == 6) g = 15;
            else if (r == 7) g = 17;
            else if (r == 8) g = $urandom_range(1, 14);
            else             g = $urandom_range(18, 40);
            tog(g);
        end

        // Lock with led high, then apply an asynchronous reset between clock edges
        tog(20); tog(16); tog(16); tog(16);
        if (led == 1'b0) tog(16);
        wait3();
        chk("arst_pre_locked", int'(locked), 1);
        chk("arst_pre_level", int'(level), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_locked", int'(locked), 0);
        chk("arst_period", int'(period), 0);
        chk("arst_level", int'(level), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/blink_decoder.md
Name: blink_decoder

Overview:
Receive-side counterpart of the LED blinker. Samples an asynchronous blink line, detects every toggle and measures the interval between toggles. Checks each interval against the nominal half-period 2^CBITS clocks and reports lock, error and timeout. Sits on the test or monitor side of a board link, watching a blinker's led output.

Parameters:
CBITS, 25, log2 of nominal half-period in clocks; nominal interval NOM = 2^CBITS
TOL, 2, allowed |interval - NOM| in clocks, inclusive; must be < NOM
LOCK_N, 4, consecutive in-tolerance intervals required to assert locked (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset; 0 = reset
led  input  1  blink line, asynchronous to clk
edge_flg  output  1  one-cycle pulse per detected toggle of led
level  output  1  synchronized led level (second synchronizer stage)
period  output  CBITS+1  last measured interval in clocks; holds between updates
locked  output  1  high while state = LOCK
err  output  1  one-cycle pulse on out-of-tolerance interval or timeout

Behaviour:
- Reset (rst=0, asynchronous, dominates everything): s1/s2/s3 sync flops 0, ivl 0, good_cnt 0, state IDLE; edge_flg 0, level 0, period 0, locked 0, err 0.
- Synchronizer: s1<=led, s2<=s1, s3<=s2; level = s2. Internal edge = s2 ^ s3.
- Latency: a led change sampled at clock edge k produces edge_flg high for the cycle after edge k+2.
- edge_flg, period, err and locked are all registered and update on the same clock edge as the edge event.
- Interval counter ivl (CBITS+1 bits): cleared to 0 on an edge, otherwise increments and saturates at MAX = 2^(CBITS+1)-1.
- Measured interval m = ivl+1 when ivl < MAX, else m = MAX. m equals the clock count between consecutive edges.
- Good interval: NOM-TOL <= m <= NOM+TOL. Compare in CBITS+2 bits so no wrap occurs.
- State IDLE, no reference edge yet:
  - On an edge: go to ACQ, good_cnt=0. period is not updated and err is not raised.
- State ACQ, on an edge: period<=m.
  - If good: good_cnt++. When good_cnt reaches LOCK_N, go to LOCK and set locked=1 on that edge.
  - If bad: err pulse, good_cnt=0, stay in ACQ.
- State LOCK, on an edge: period<=m.
  - If good: stay in LOCK.
  - If bad: err pulse, locked=0, go to ACQ, good_cnt=0.
- Timeout: in ACQ or LOCK, on the cycle ivl transitions to MAX: err pulse once, locked=0, go to IDLE, good_cnt=0.
  - While ivl is held at MAX, no further err pulses.
  - The next edge re-enters ACQ without updating period.
- Simultaneous edge and timeout cannot occur, because an edge clears ivl; edge handling has priority.
- edge_flg pulses on every edge in every state, including IDLE.

Test Plan:
(Override CBITS=4, TOL=1, LOCK_N=3, so NOM=16 and MAX=31.)
- Reset: hold rst=0 with led toggling -> all outputs 0, period 0; release rst -> outputs stay 0 until the first synchronized edge.
- Steady blink: toggle led every 16 clk -> edge_flg pulses 3 cycles after each toggle. period=16 from the 2nd edge. locked=1 on the 4th edge's update. err never pulses.
- Tolerance: in LOCK, intervals 15 and 17 -> locked stays 1, period shows 15/17. Interval 18 -> err pulses 1 cycle, locked=0, state ACQ; 3 more 16-intervals -> locked=1 again.
- Timeout: stop toggling in LOCK -> 31 clk after the last edge_flg, err pulses once and locked=0. Next toggle -> edge_flg=1, period unchanged, err=0.
- Glitch: one-cycle led pulse in LOCK -> two edges 1 clk apart; period=1 on the second, err pulse, locked=0.
- Async reset mid-lock: drive rst=0 between clock edges -> locked, period and level go to 0 immediately, without waiting for clk.
